// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter
// ----------------------------------------------------------------------------
// Shares one single-port data memory between CORES requesters. Arbitration is
// round-robin, starting just after the most recently granted core. Only one
// access is in flight at a time. A write takes two cycles (IDLE, ACCESS). A
// read takes three cycles (IDLE, ACCESS, RDATA), because memory read data
// comes back one cycle after the strobe.
//
// Optional feature (macro DMEM_ARB_LOCK_EN):
//   A core that holds lock during its ACCESS cycle becomes the lock owner.
//   While lock[owner] stays high, only the owner's req is considered. The
//   owner is released in the first IDLE cycle where lock[owner] is low. In
//   the default build the lock input is ignored and no owner state exists.
//
// Parameters:
//   CORES   number of requesting cores (2..8)
//   ADDR_W  word-address width
//   DATA_W  data word width
//
// Ports:
//   clk        in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   req        in   [CORES]         per-core access request
//   we         in   [CORES]         per-core write enable (qualified by req)
//   addr       in   [CORES*ADDR_W]  per-core address, core i at [i*ADDR_W +: ADDR_W]
//   wdata      in   [CORES*DATA_W]  per-core write data, same packing
//   lock       in   [CORES]         per-core lock request (lock build only)
//   grant      out  [CORES]         one-hot pulse in the cycle the access issues
//   rvalid     out  [CORES]         one-hot pulse while read data is on rdata
//   rdata      out  [DATA_W]        shared read-return data, holds last value
//   mem_en     out  memory access strobe
//   mem_we     out  memory write enable
//   mem_addr   out  [ADDR_W]        memory address
//   mem_wdata  out  [DATA_W]        memory write data
//   mem_rdata  in   [DATA_W]        memory read data, valid one cycle after strobe
// ============================================================================
module dmem_arbiter #(
    parameter int CORES  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [CORES-1:0]        req,
    input  logic [CORES-1:0]        we,
    input  logic [CORES*ADDR_W-1:0] addr,
    input  logic [CORES*DATA_W-1:0] wdata,
    input  logic [CORES-1:0]        lock,
    output logic [CORES-1:0]        grant,
    output logic [CORES-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata
);

    localparam int PTR_W = $clog2(CORES);
    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(CORES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_sel;
    logic [PTR_W-1:0] w_winner;
    logic [PTR_W-1:0] w_scanIdx;
    logic             w_anyReq;
    logic [CORES-1:0] w_reqMask;
    logic             r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] r_rdata;

`ifdef DMEM_ARB_LOCK_EN
    logic [PTR_W-1:0] r_owner;
    logic             r_ownerValid;
    logic             w_ownerHold;

    // While the owner still asserts lock, everyone else is masked out. Once
    // lock drops, the mask opens in that same IDLE cycle.
    assign w_ownerHold = r_ownerValid && lock[r_owner];
    assign w_reqMask   = w_ownerHold ? (req & (CORES'(1) << r_owner)) : req;

    // The owner is captured when a locked access issues. It is released in
    // the first IDLE cycle that sees the owner's lock low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner      <= '0;
            r_ownerValid <= 1'b0;
        end else if (r_state == ACCESS && lock[r_sel]) begin
            r_owner      <= r_sel;
            r_ownerValid <= 1'b1;
        end else if (r_state == IDLE && r_ownerValid && !lock[r_owner]) begin
            r_ownerValid <= 1'b0;
        end
    end
`else
    logic w_unusedLock;

    assign w_unusedLock = ^lock;
    assign w_reqMask    = req;
`endif

    // Round-robin scan: start at ptr+1 and wrap modulo CORES. The first
    // requester found wins.
    always_comb begin
        w_anyReq  = 1'b0;
        w_winner  = r_ptr;
        w_scanIdx = '0;
        for (int k = 1; k <= CORES; k++) begin
            w_scanIdx = PTR_W'((int'(r_ptr) + k) % CORES);
            if (!w_anyReq && w_reqMask[w_scanIdx]) begin
                w_anyReq = 1'b1;
                w_winner = w_scanIdx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // grant, rvalid and mem_en are decoded from the state. An asynchronous
    // reset therefore silences them immediately.
    always_comb begin
        w_nextState = r_state;
        grant       = '0;
        rvalid      = '0;
        mem_en      = 1'b0;
        rdata       = r_rdata;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                mem_en      = 1'b1;
                grant       = CORES'(1) << r_sel;
                w_nextState = r_memWe ? IDLE : RDATA;
            end
            RDATA: begin
                rvalid      = CORES'(1) << r_sel;
                rdata       = mem_rdata;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The winner's request is latched when it is accepted in IDLE. ptr moves
    // only when the access actually issues. rdata keeps a copy of the last
    // returned word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel      <= '0;
            r_ptr      <= PTR_RESET;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_rdata    <= '0;
        end else begin
            if (r_state == IDLE && w_anyReq) begin
                r_sel      <= w_winner;
                r_memWe    <= we[w_winner];
                r_memAddr  <= addr[int'(w_winner) * ADDR_W +: ADDR_W];
                r_memWdata <= wdata[int'(w_winner) * DATA_W +: DATA_W];
            end
            if (r_state == ACCESS) begin
                r_ptr <= r_sel;
            end
            if (r_state == RDATA) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for dmem_arbiter (CORES=4, 32-bit address and data).
// A transaction-level model predicts each grant and read return, including
// the cycle it should appear, and pushes the prediction into a queue. A
// negedge monitor compares the DUT against the front of that queue. A small
// behavioural memory answers the DUT's memory port.
// ============================================================================
module tb_dmem_arbiter;

    localparam int CORES     = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_WORDS = 16;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic [CORES-1:0]        req = '0;
    logic [CORES-1:0]        we = '0;
    logic [CORES*ADDR_W-1:0] addr = '0;
    logic [CORES*DATA_W-1:0] wdata = '0;
    logic [CORES-1:0]        lock = '0;
    logic [CORES-1:0]        grant;
    logic [CORES-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata = '0;

    dmem_arbiter #(.CORES(CORES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .lock      (lock),
        .grant     (grant),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural single-port memory: a read returns data one cycle after the
    // strobe.
    logic [DATA_W-1:0] benchMem [MEM_WORDS];
    bit                memLoaded = 1'b0;

    function automatic logic [DATA_W-1:0] initWord(input int k);
        return DATA_W'(k * k + 5);
    endfunction

    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int k = 0; k < MEM_WORDS; k++) benchMem[k] <= initWord(k);
            memLoaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) benchMem[mem_addr[3:0]] <= mem_wdata;
            else        mem_rdata <= benchMem[mem_addr[3:0]];
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at cycle %0d", name, actual, required, cycle);
        end
    endtask

    // Expected event: kind 0 is a grant, kind 1 is a read return.
    typedef struct {
        int                kind;
        int                core;
        int                cyc;
        bit                isWrite;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } expEvt_t;

    typedef struct {
        int core;
        int cyc;
    } grantRec_t;

    expEvt_t           expQ[$];
    grantRec_t         grantLog[$];
    logic [DATA_W-1:0] monLastRdata = '0;

    function automatic int onehotIndex(input logic [CORES-1:0] v);
        for (int i = 0; i < CORES; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin : monitor
        expEvt_t          e;
        bit               due;
        logic [CORES-1:0] expGrant;
        logic [CORES-1:0] expRvalid;
        logic             expEn;
        grantRec_t        rec;
        if (reset_n) begin
            due       = (expQ.size() > 0) && (expQ[0].cyc == cycle);
            expGrant  = '0;
            expRvalid = '0;
            expEn     = 1'b0;
            if (due) begin
                e = expQ.pop_front();
                if (e.kind == 0) begin
                    expGrant[e.core] = 1'b1;
                    expEn            = 1'b1;
                end else begin
                    expRvalid[e.core] = 1'b1;
                    monLastRdata      = e.d;
                end
            end
            if (grant != '0) begin
                rec.core = onehotIndex(grant);
                rec.cyc  = cycle;
                grantLog.push_back(rec);
            end
            checkOutput("grant", grant, expGrant);
            checkOutput("rvalid", rvalid, expRvalid);
            checkOutput("mem_en", mem_en, expEn);
            checkOutput("rdata", rdata, monLastRdata);
            if (due && e.kind == 0) begin
                checkOutput("mem_we", mem_we, e.isWrite);
                checkOutput("mem_addr", mem_addr, e.a);
                if (e.isWrite) checkOutput("mem_wdata", mem_wdata, e.d);
            end
        end
    end

    // Per-core requester state and transaction-level arbiter model.
    bit                corePending   [CORES];
    bit                coreWe        [CORES];
    logic [ADDR_W-1:0] coreAddr      [CORES];
    logic [DATA_W-1:0] coreWdata     [CORES];
    bit                coreLock      [CORES];
    int                coreReleaseAt [CORES];

    int                mdlPtr;
    int                mdlIdleCycle;
    bit                mdlOwnerValid;
    int                mdlOwner;
    logic [DATA_W-1:0] mdlMem [MEM_WORDS];

    bit randomMode      = 1'b0;
    bit continuousReads = 1'b0;
    bit drainMode       = 1'b0;

    task automatic driveInputs();
        for (int i = 0; i < CORES; i++) begin
            req[i]                    = corePending[i];
            we[i]                     = coreWe[i];
            lock[i]                   = coreLock[i];
            addr[i*ADDR_W +: ADDR_W]  = coreAddr[i];
            wdata[i*DATA_W +: DATA_W] = coreWdata[i];
        end
    endtask

    task automatic applyStimulus(input int core, input bit isWrite, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d, input bit lk);
        corePending[core]   = 1'b1;
        coreWe[core]        = isWrite;
        coreAddr[core]      = a;
        coreWdata[core]     = d;
        coreLock[core]      = lk;
        coreReleaseAt[core] = -1;
    endtask

    task automatic pushExp(input int kind, input int core, input int cyc, input bit isWrite,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        expEvt_t e;
        e.kind    = kind;
        e.core    = core;
        e.cyc     = cyc;
        e.isWrite = isWrite;
        e.a       = a;
        e.d       = d;
        expQ.push_back(e);
    endtask

    // One arbitration opportunity for requests driven in cycle n. A grant
    // shows in cycle n+1 and read data in n+2. The arbiter is free again in
    // n+2 after a write or n+3 after a read.
    task automatic modelArbitrate(input int n);
        bit eligible [CORES];
        int winner;
        int idx;
        for (int i = 0; i < CORES; i++) eligible[i] = corePending[i] && (coreReleaseAt[i] < 0);
`ifdef DMEM_ARB_LOCK_EN
        if (mdlOwnerValid) begin
            if (coreLock[mdlOwner]) begin
                for (int i = 0; i < CORES; i++) if (i != mdlOwner) eligible[i] = 1'b0;
            end else begin
                mdlOwnerValid = 1'b0;
            end
        end
`endif
        winner = -1;
        for (int k = 1; k <= CORES; k++) begin
            idx = (mdlPtr + k) % CORES;
            if (winner < 0 && eligible[idx]) winner = idx;
        end
        if (winner < 0) begin
            mdlIdleCycle = n + 1;
        end else begin
            pushExp(0, winner, n + 1, coreWe[winner], coreAddr[winner], coreWdata[winner]);
            if (coreWe[winner]) begin
                mdlMem[coreAddr[winner][3:0]] = coreWdata[winner];
                mdlIdleCycle = n + 2;
            end else begin
                pushExp(1, winner, n + 2, 1'b0, coreAddr[winner], mdlMem[coreAddr[winner][3:0]]);
                mdlIdleCycle = n + 3;
            end
            mdlPtr                = winner;
            coreReleaseAt[winner] = n + 2;
`ifdef DMEM_ARB_LOCK_EN
            if (coreLock[winner]) begin
                mdlOwnerValid = 1'b1;
                mdlOwner      = winner;
            end
`endif
        end
    endtask

    // Called once per cycle, just after the rising edge.
    task automatic stepCycle();
        int n;
        n = cycle;
        for (int i = 0; i < CORES; i++) begin
            if (corePending[i] && coreReleaseAt[i] == n) begin
                corePending[i]   = 1'b0;
                coreReleaseAt[i] = -1;
            end
        end
        for (int i = 0; i < CORES; i++) begin
            if (!corePending[i]) begin
                if (drainMode) begin
                    coreLock[i] = 1'b0;
                end else if (continuousReads) begin
                    applyStimulus(i, 1'b0, ADDR_W'(i + 8), '0, 1'b0);
                end else if (randomMode && $urandom_range(0, 2) == 0) begin
                    applyStimulus(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 255)),
                                  $urandom, ($urandom_range(0, 3) == 0));
                end
            end
        end
        if (n >= mdlIdleCycle) modelArbitrate(n);
        driveInputs();
    endtask

    task automatic runCycles(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            stepCycle();
        end
    endtask

    function automatic bit anyPending();
        for (int i = 0; i < CORES; i++) if (corePending[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drainAll(input string tag);
        int budget;
        budget    = 400;
        drainMode = 1'b1;
        while ((anyPending() || expQ.size() != 0) && budget > 0) begin
            @(posedge clk);
            #1;
            stepCycle();
            budget--;
        end
        checkOutput({tag, "_drained"}, (anyPending() || expQ.size() != 0), 0);
        drainMode = 1'b0;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        for (int i = 0; i < CORES; i++) begin
            corePending[i]   = 1'b0;
            coreLock[i]      = 1'b0;
            coreReleaseAt[i] = -1;
        end
        driveInputs();
        expQ.delete();
        monLastRdata  = '0;
        mdlPtr        = CORES - 1;
        mdlOwnerValid = 1'b0;
        mdlOwner      = 0;
        repeat (2) @(posedge clk);
        #3;
        reset_n      = 1'b1;
        mdlIdleCycle = cycle + 1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int reqCycle;
        for (int i = 0; i < CORES; i++) begin
            coreWe[i]        = 1'b0;
            coreAddr[i]      = '0;
            coreWdata[i]     = '0;
            coreReleaseAt[i] = -1;
        end
        for (int k = 0; k < MEM_WORDS; k++) mdlMem[k] = initWord(k);

        // Reset values
        doReset();
        checkOutput("reset_grant", grant, 0);
        checkOutput("reset_rvalid", rvalid, 0);
        checkOutput("reset_mem_en", mem_en, 0);
        checkOutput("reset_mem_we", mem_we, 0);
        checkOutput("reset_mem_addr", mem_addr, 0);
        checkOutput("reset_mem_wdata", mem_wdata, 0);
        checkOutput("reset_rdata", rdata, 0);

        // Lone write by core 2: addr 5, data 9
        grantLog.delete();
        @(posedge clk);
        #1;
        reqCycle = cycle;
        applyStimulus(2, 1'b1, 32'd5, 32'd9, 1'b0);
        stepCycle();
        drainAll("write_core2");
        checkOutput("write_core2_count", grantLog.size(), 1);
        if (grantLog.size() >= 1) begin
            checkOutput("write_core2_who", grantLog[0].core, 2);
            checkOutput("write_core2_when", grantLog[0].cyc, reqCycle + 1);
        end

        // Core 1 reads addr 3, which holds 14
        @(posedge clk);
        #1;
        applyStimulus(1, 1'b0, 32'd3, '0, 1'b0);
        stepCycle();
        drainAll("read_core1");
        checkOutput("read_core1_hold", rdata, 32'd14);

        // All cores reading continuously from reset
        doReset();
        grantLog.delete();
        continuousReads = 1'b1;
        runCycles(16);
        continuousReads = 1'b0;
        drainAll("rr_all");
        checkOutput("rr_all_count", (grantLog.size() >= 5), 1);
        if (grantLog.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                checkOutput("rr_all_order", grantLog[i].core, i % CORES);
                if (i > 0) checkOutput("rr_all_spacing", grantLog[i].cyc - grantLog[i-1].cyc, 3);
            end
        end

        // Reset while core 3 is in its read-return cycle
        doReset();
        @(posedge clk);
        #1;
        applyStimulus(3, 1'b0, 32'd7, '0, 1'b0);
        stepCycle();
        runCycles(2);
        #1;
        checkOutput("midread_rvalid_before", rvalid, 4'b1000);
        reset_n = 1'b0;
        #1;
        checkOutput("midread_rvalid_after", rvalid, 0);
        checkOutput("midread_mem_en_after", mem_en, 0);
        checkOutput("midread_rdata_after", rdata, 0);
        doReset();
        grantLog.delete();
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 32'd2, '0, 1'b0);
        applyStimulus(3, 1'b0, 32'd4, '0, 1'b0);
        stepCycle();
        drainAll("after_reset");
        checkOutput("after_reset_count", grantLog.size(), 2);
        if (grantLog.size() >= 1) checkOutput("after_reset_first", grantLog[0].core, 0);

        // Randomized traffic
        doReset();
        randomMode = 1'b1;
        runCycles(1500);
        randomMode = 1'b0;
        drainAll("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter CORES, default 4, meaning number of requesting cores (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning word-address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port req  input  CORES  per-core access request, bit i = core i.
REQ-007 SHALL have port we  input  CORES  per-core write enable, qualified by req.
REQ-008 SHALL have port addr  input  CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port wdata  input  CORES*DATA_W  per-core write data, same packing as addr.
REQ-010 SHALL have port lock  input  CORES  per-core lock request; used only when DMEM_ARB_LOCK_EN is defined.
REQ-011 SHALL have port grant  output  CORES  one-hot, one-cycle pulse when a core's access is issued.
REQ-012 SHALL have port rvalid  output  CORES  one-hot, one-cycle pulse when read data for a core is on rdata.
REQ-013 SHALL have port rdata  output  DATA_W  shared read-return data.
REQ-014 SHALL have port mem_en  output  1  memory access strobe.
REQ-015 SHALL have port mem_we  output  1  memory write enable.
REQ-016 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-017 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-018 SHALL have port mem_rdata  input  DATA_W  memory read data, valid one cycle after a read strobe.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, RDATA.
REQ-020 In IDLE with any req bit set, SHALL pick winner by round-robin: first set bit scanning ptr+1, ptr+2, ... modulo CORES; register sel, we/addr/wdata of winner into mem_* registers; go ACCESS.
REQ-021 In IDLE with req==0, SHALL stay in IDLE with mem_en=0 and grant=0.
REQ-022 In ACCESS, SHALL drive mem_en=1 and grant[sel]=1 for exactly this cycle; set ptr=sel; go RDATA if mem_we=0, else IDLE.
REQ-023 In RDATA, SHALL drive rvalid[sel]=1 and rdata=mem_rdata (combinational pass-through); mem_en=0; go IDLE.
REQ-024 rdata SHALL hold its last returned value outside RDATA (registered copy); rvalid SHALL be zero outside RDATA.
REQ-025 Latency req-to-grant SHALL be 2 cycles when uncontended; write = 2 cycles/access, read = 3 cycles/access; no overlap between accesses.
REQ-026 Requesters SHALL hold req/we/addr/wdata stable until grant; req bits are sampled only in IDLE; a core deasserting req before grant is simply not selected.
REQ-027 With all CORES requesting continuously, each core SHALL be granted exactly once per CORES consecutive grants.
REQ-028 ptr wrap-around: ptr=CORES-1 SHALL scan starting at core 0.
REQ-029 grant, rvalid SHALL never have more than one bit set; grant and rvalid SHALL never be asserted in the same cycle.

Reset
REQ-030 On reset_n low, SHALL asynchronously force state=IDLE, grant=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, ptr=CORES-1 (core 0 wins first), lock owner cleared.
REQ-031 Reset during ACCESS or RDATA SHALL abandon the access; no grant/rvalid pulse after reset_n rises until a new arbitration.

Configuration
REQ-032 With DMEM_ARB_LOCK_EN defined: if lock[sel]=1 at ACCESS, sel becomes lock owner; while owner held, IDLE SHALL consider only owner's req; ownership releases in the first IDLE cycle where lock[owner]=0, and arbitration that cycle SHALL proceed normally.
REQ-033 Without DMEM_ARB_LOCK_EN: lock input SHALL be ignored; no owner register synthesized; pure round-robin.

Verification
REQ-034 Reset, core 2 writes addr 5 data 32'd9 alone -> grant=4'b0100 in 2nd cycle after req, mem_we=1, mem_addr=5, mem_wdata=9 same cycle.
REQ-035 Memory[3]=32'd14, core 1 reads addr 3 -> grant[1] at cycle 2, rvalid=4'b0010 and rdata=14 at cycle 3.
REQ-036 All four cores request reads continuously from reset -> grant order 0,1,2,3,0; one grant per 3 cycles.
REQ-037 Core 3 mid-read (state RDATA), reset_n pulsed low -> rvalid=0, mem_en=0 immediately; next grant goes to core 0 if requesting.
REQ-038 DMEM_ARB_LOCK_EN defined, core 1 read with lock=1 then write, cores 0,2 requesting -> grants 1,1, then 2 after lock[1] drops; undefined -> grants 1,2,0.
